mult_share_arbiter: RTL and testbench

//  Round-robin controller that shares one 8x8 sequential multiplier datapath among NUM_REQ requesters.

---
 rtl/mult_arb_pkg.sv | 15 +
 rtl/mult_share_arbiter_rr_picker.sv | 33 +++
 rtl/mult_share_arbiter.sv | 133 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types for the multiplier-sharing arbiter: FSM state encoding and default ID width.
// Optional zero-operand bypass is selected with MULT_ARB_ZERO_BYPASS_EN (see mult_share_arbiter).
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = $clog2(NUM_REQ);

endpackage

// File: rtl/mult_share_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid requester at or after the pointer, wrapping.
// Produces a one-hot grant, its index, and whether anything was found.
module rr_picker
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     id_o,
    output logic               any_o
);

    int idx;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        any_o   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && valid_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one external sequential multiplier among NUM_REQ clients.
// Define MULT_ARB_ZERO_BYPASS_EN to answer zero-operand requests without touching the multiplier.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [2*WIDTH-1:0]         rsp_prod,
    output logic                       rsp_err,
    output logic                       mul_load,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic                       mul_valid,
    input  logic [2*WIDTH-1:0]         mul_prod,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MUL_LAT + 1);

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0] rsp_prod_q, rsp_prod_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     pick_id;
    logic               pick_any;
    logic [WIDTH-1:0]   sel_a, sel_b;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .id_o    (pick_id),
        .any_o   (pick_any)
    );

    assign sel_a = req_a[pick_id*WIDTH +: WIDTH];
    assign sel_b = req_b[pick_id*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            cnt_q      <= '0;
            rsp_id_q   <= '0;
            rsp_prod_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            cnt_q      <= cnt_d;
            rsp_id_q   <= rsp_id_d;
            rsp_prod_q <= rsp_prod_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        cnt_d      = cnt_q;
        rsp_id_d   = rsp_id_q;
        rsp_prod_d = rsp_prod_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    rsp_id_d = pick_id;
                    ptr_d    = (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + IDW'(1);
                    cnt_d    = CW'(MUL_LAT - 1);
                    state_d  = EXEC;
`ifdef MULT_ARB_ZERO_BYPASS_EN
                    if (sel_a == '0 || sel_b == '0) begin
                        rsp_prod_d = '0;
                        rsp_err_d  = 1'b0;
                        state_d    = RESP;
                    end
`endif
                end
            end
            // Operands stay on the bus for exactly MUL_LAT cycles.
            EXEC: begin
                if (cnt_q == '0) state_d = CAPT;
                else             cnt_d   = cnt_q - CW'(1);
            end
            CAPT: begin
                rsp_prod_d = mul_prod;
                rsp_err_d  = ~mul_valid;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is suppressed while reset is held so no handshake can be seen during it.
    assign req_ready = (state_q == IDLE && !reset) ? grant : '0;
    assign mul_load  = (state_q == EXEC);
    assign mul_a     = mul_load ? op_a_q : '0;
    assign mul_b     = mul_load ? op_b_q : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_prod  = rsp_prod_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios then randomized traffic against a
// round-robin/arithmetic reference model, with a behavioural sequential multiplier attached.
module tb_mult_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [15:0]    rsp_prod;
    logic           rsp_err, mul_load;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_valid;
    logic [15:0]    mul_prod;
    logic           busy;

    mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b),
        .mul_valid(mul_valid), .mul_prod(mul_prod), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: product valid once load has been held LAT cycles.
    int          mcnt;
    logic [15:0] mprod_q;
    logic        mvld_q;
    logic        mul_kill;
    logic [15:0] junk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt <= 0; mprod_q <= '0; mvld_q <= 1'b0;
        end else if (mul_load) begin
            mcnt    <= mcnt + 1;
            mprod_q <= {8'd0, mul_a} * {8'd0, mul_b};
            mvld_q  <= (mcnt + 1 >= LAT);
        end else begin
            mcnt <= 0; mvld_q <= 1'b0;
        end
    end

    assign mul_valid = mvld_q & ~mul_kill;
    assign mul_prod  = mul_kill ? junk : mprod_q;

    int npass = 0;
    int ntot  = 0;

    // Reference state: what each client is presenting, and the round-robin pointer.
    bit         tv [N];
    logic [7:0] ta [N];
    logic [7:0] tb [N];
    int         ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = tv[i];
            req_a[i*W +: W]    = ta[i];
            req_b[i*W +: W]    = tb[i];
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < N; k++)
            if (tv[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [7:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 8'd0;
            1:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Precondition: DUT idle, called #1 after an edge. Returns #1 after the edge leaving RESP.
    task automatic run_op(input int id, input bit kill, input logic [15:0] jk, input int bp);
        logic [7:0]  ea, eb;
        logic [15:0] ep, hold;
        bit          byp;
        int          lat, loads;
        ea  = ta[id];
        eb  = tb[id];
        byp = 1'b0;
`ifdef MULT_ARB_ZERO_BYPASS_EN
        byp = (ea == 8'd0 || eb == 8'd0);
`endif
        drive();
        mul_kill  = kill;
        junk      = jk;
        rsp_ready = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
        chk("grant", req_ready, 32'd1 << id);
        step();
        tv[id] = 1'b0;
        drive();
        ptr = (id + 1) % N;
        chk("busy_after_hs", busy, 1);
        chk("ready_when_busy", req_ready, 0);
        lat   = 1;
        loads = 0;
        while (!rsp_valid && lat < 40) begin
            if (mul_load) begin
                loads++;
                chk("mul_a", mul_a, ea);
                chk("mul_b", mul_b, eb);
            end
            step();
            lat++;
        end
        ep = byp ? 16'd0 : (kill ? jk : {8'd0, ea} * {8'd0, eb});
        chk("latency", lat, byp ? 1 : LAT + 2);
        chk("load_cycles", loads, byp ? 0 : LAT);
        chk("rsp_id", rsp_id, id);
        chk("rsp_prod", rsp_prod, ep);
        chk("rsp_err", rsp_err, (kill && !byp) ? 1 : 0);
        mul_kill = 1'b0;
        if (bp > 0) begin
            rsp_ready = 1'b0;
            hold      = rsp_prod;
            repeat (bp) begin
                step();
                chk("bp_valid", rsp_valid, 1);
                chk("bp_prod", rsp_prod, hold);
                chk("bp_ready", req_ready, 0);
            end
            rsp_ready = 1'b1;
        end
        step();
        chk("rsp_drop", rsp_valid, 0);
        chk("back_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int id;
        reset     = 1'b1;
        rsp_ready = 1'b0;
        mul_kill  = 1'b0;
        junk      = '0;
        for (int i = 0; i < N; i++) begin tv[i] = 1'b0; ta[i] = '0; tb[i] = '0; end
        tv[0] = 1'b1; ta[0] = 8'd3; tb[0] = 8'd4;
        drive();
        #12;
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load", mul_load, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        tv[0] = 1'b0;
        drive();
        @(negedge clk) reset = 1'b0;
        ptr = 0;
        step();
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_prod", rsp_prod, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("no_valid_no_grant", req_ready, 0);

        // Single request with known operands.
        tv[2] = 1'b1; ta[2] = 8'd13; tb[2] = 8'd11;
        run_op(2, 1'b0, 16'h0, 0);

        // Backpressure with another client waiting.
        tv[0] = 1'b1; ta[0] = 8'd200; tb[0] = 8'd3;
        tv[1] = 1'b1; ta[1] = 8'd255; tb[1] = 8'd255;
        run_op(0, 1'b0, 16'h0, 5);
        run_op(1, 1'b0, 16'h0, 0);

        // Multiplier fails to raise valid.
        tv[3] = 1'b1; ta[3] = 8'd5; tb[3] = 8'd6;
        run_op(3, 1'b1, 16'hBEEF, 0);

        // Zero operand.
        tv[1] = 1'b1; ta[1] = 8'd0; tb[1] = 8'd200;
        run_op(model_pick(), 1'b0, 16'h0, 1);

        // Reset in the middle of EXEC; pointer must return to 0.
        tv[0] = 1'b1; ta[0] = 8'd7; tb[0] = 8'd9;
        drive();
        #1;
        chk("pre_rst_grant", req_ready, 32'd1 << model_pick());
        step();
        tv[0] = 1'b1; tv[1] = 1'b1; ta[1] = 8'd2; tb[1] = 8'd2;
        drive();
        chk("pre_rst_exec", mul_load, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_load", mul_load, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp", rsp_valid, 0);
        for (int i = 0; i < N; i++) tv[i] = 1'b0;
        drive();
        @(negedge clk) reset = 1'b0;
        ptr = 0;
        step();
        chk("post_rst_rsp", rsp_valid, 0);

        // All requesters valid: strict rotation 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) begin
                tv[i] = 1'b1; ta[i] = 8'(17 * i + k); tb[i] = 8'(3 + i);
            end
            run_op(k % N, 1'b0, 16'h0, 0);
        end

        // Randomized traffic: clients come, go, and re-arm with new operands.
        repeat (60) begin
            for (int i = 0; i < N; i++) begin
                if (tv[i]) begin
                    if ($urandom_range(0, 4) == 0) tv[i] = 1'b0;
                end else if ($urandom_range(0, 2) != 0) begin
                    tv[i] = 1'b1; ta[i] = rnd_op(); tb[i] = rnd_op();
                end
            end
            id = model_pick();
            if (id < 0) begin
                drive();
                #1;
                chk("rand_no_grant", req_ready, 0);
                step();
                chk("rand_stay_idle", busy, 0);
            end else begin
                run_op(id, $urandom_range(0, 7) == 0, 16'($urandom), int'($urandom_range(0, 3)));
            end
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
